// File: rtl/dmem_access_ctrl_if.sv
// Request/acknowledge data-memory bus between the MEM-stage sequencer and memory.
interface dmem_access_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
                  input  bus_ack, bus_rdata);
  modport slave  (input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
                  output bus_ack, bus_rdata);
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store sequencer: stalls the pipeline while a bus access is outstanding.
// Optional bus timeout abort is enabled with `define DMEM_TIMEOUT_EN.
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read_mem,
  input  logic                 mem_write_mem,
  input  logic [2:0]           funct3_mem,
  input  logic [31:0]          addr_mem,
  input  logic [31:0]          wdata_mem,
  dmem_access_ctrl_if.master   bus,
  output logic                 stall,
  output logic                 wb_bubble,
  output logic [31:0]          mem_data_mem,
  output logic                 misalign,
  output logic                 bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t      r_state, w_next;
  logic        r_req, r_we, r_ld;
  logic [31:0] r_addr, r_wdata, r_data;
  logic [3:0]  r_wstrb;
  logic [2:0]  r_f3;
  logic [1:0]  r_alo;

  logic        w_access, w_is_load, w_is_store, w_mis, w_issue, w_ack;
  size_t       w_size;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata, w_fmt;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // A simultaneous read and write is treated as a load.
  assign w_access   = mem_read_mem | mem_write_mem;
  assign w_is_load  = mem_read_mem;
  assign w_is_store = mem_write_mem & ~mem_read_mem;

  always_comb begin
    w_size = SZ_W;
    if (w_is_load) begin
      case (funct3_mem)
        3'd0, 3'd4: w_size = SZ_B;
        3'd1, 3'd5: w_size = SZ_H;
        default:    w_size = SZ_W;
      endcase
    end else begin
      case (funct3_mem)
        3'd0:    w_size = SZ_B;
        3'd1:    w_size = SZ_H;
        default: w_size = SZ_W;
      endcase
    end
  end

  assign w_mis = ((w_size == SZ_H) & addr_mem[0]) |
                 ((w_size == SZ_W) & (|addr_mem[1:0]));

  always_comb begin
    w_strb  = 4'b0000;
    w_wdata = wdata_mem;
    case (w_size)
      SZ_B: begin
        w_strb  = 4'b0001 << addr_mem[1:0];
        w_wdata = {4{wdata_mem[7:0]}};
      end
      SZ_H: begin
        w_strb  = 4'b0011 << addr_mem[1:0];
        w_wdata = {2{wdata_mem[15:0]}};
      end
      default: begin
        w_strb  = 4'b1111;
        w_wdata = wdata_mem;
      end
    endcase
    if (!w_is_store) w_strb = 4'b0000;
  end

  // Lane select uses the offset captured at issue, since EX/MEM may move on during DONE.
  always_comb begin
    case (r_alo)
      2'd0:    w_byte = bus.bus_rdata[7:0];
      2'd1:    w_byte = bus.bus_rdata[15:8];
      2'd2:    w_byte = bus.bus_rdata[23:16];
      default: w_byte = bus.bus_rdata[31:24];
    endcase
    w_half = r_alo[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (r_f3)
      3'd0:    w_fmt = {{24{w_byte[7]}}, w_byte};
      3'd4:    w_fmt = {24'd0, w_byte};
      3'd1:    w_fmt = {{16{w_half[15]}}, w_half};
      3'd5:    w_fmt = {16'd0, w_half};
      default: w_fmt = bus.bus_rdata;
    endcase
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] r_cnt;
  logic          r_err, w_tout;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    stall     = 1'b0;
    wb_bubble = 1'b0;
    misalign  = 1'b0;
    w_issue   = 1'b0;
    w_ack     = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    w_tout    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          wb_bubble = 1'b1;
          if (w_mis) begin
            misalign = 1'b1;
          end else begin
            stall   = 1'b1;
            w_issue = 1'b1;
            w_next  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        stall     = 1'b1;
        wb_bubble = 1'b1;
        if (bus.bus_ack) begin
          w_ack  = 1'b1;
          w_next = S_DONE;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (r_cnt == TO_LAST) begin
          w_tout = 1'b1;
          w_next = S_DONE;
        end
`endif
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_ld    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
      r_f3    <= 3'd0;
      r_alo   <= 2'd0;
      r_data  <= 32'd0;
    end else begin
      if (w_issue) begin
        r_req   <= 1'b1;
        r_we    <= w_is_store;
        r_ld    <= w_is_load;
        r_addr  <= {addr_mem[31:2], 2'b00};
        r_wdata <= w_is_store ? w_wdata : 32'd0;
        r_wstrb <= w_strb;
        r_f3    <= funct3_mem;
        r_alo   <= addr_mem[1:0];
      end
      if (w_ack) begin
        r_req  <= 1'b0;
        r_data <= r_ld ? w_fmt : 32'd0;
      end
`ifdef DMEM_TIMEOUT_EN
      if (w_tout) begin
        r_req  <= 1'b0;
        r_data <= 32'd0;
      end
`endif
    end
  end

`ifdef DMEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_tout;
      if (w_issue)                                  r_cnt <= '0;
      else if (r_state == S_BUSY && !bus.bus_ack)   r_cnt <= r_cnt + 1'b1;
    end
  end
  assign bus_err = r_err;
`else
  assign bus_err = 1'b0;
`endif

  assign bus.bus_req   = r_req;
  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_wdata = r_wdata;
  assign bus.bus_wstrb = r_wstrb;
  assign mem_data_mem  = r_data;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl; the bench plays the memory slave.
module tb_dmem_access_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_mem, mem_write_mem;
  logic [2:0]  funct3_mem;
  logic [31:0] addr_mem, wdata_mem;
  logic        stall, wb_bubble, misalign, bus_err;
  logic [31:0] mem_data_mem;

  dmem_access_ctrl_if bus();

  dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
    .funct3_mem(funct3_mem), .addr_mem(addr_mem), .wdata_mem(wdata_mem),
    .bus(bus),
    .stall(stall), .wb_bubble(wb_bubble), .mem_data_mem(mem_data_mem),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          a_stalls;
  logic [31:0] a_data;
  logic        a_err, a_stable, a_we;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_wstrb;

  // waits < 0 means never acknowledge.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int waits, input logic [31:0] rdat);
    int  cyc, busy;
    bit  done;
    cyc = 0; busy = 0; done = 0;
    a_stalls = 0; a_stable = 1'b1; a_data = 32'hx; a_err = 1'bx;
    @(posedge clk); #1;
    mem_read_mem = rd; mem_write_mem = wr; funct3_mem = f3;
    addr_mem = a; wdata_mem = wd;
    while (!done && cyc < 200) begin
      @(negedge clk); cyc++;
      if (stall) a_stalls++;
      if (bus.bus_req) begin
        busy++;
        if (busy == 1) begin
          a_we = bus.bus_we; a_addr = bus.bus_addr;
          a_wdata = bus.bus_wdata; a_wstrb = bus.bus_wstrb;
        end else if (bus.bus_we !== a_we || bus.bus_addr !== a_addr ||
                     bus.bus_wdata !== a_wdata || bus.bus_wstrb !== a_wstrb) begin
          a_stable = 1'b0;
        end
        if (busy == waits + 1) begin
          bus.bus_ack = 1'b1; bus.bus_rdata = rdat;
        end
      end else if (a_stalls > 0 && !stall) begin
        done = 1; a_data = mem_data_mem; a_err = bus_err;
      end
      @(posedge clk); #1;
      bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
    end
    mem_read_mem = 0; mem_write_mem = 0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL access_done: no DONE within budget addr=%h", a);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    mem_read_mem = 0; mem_write_mem = 0; funct3_mem = 0; addr_mem = 0; wdata_mem = 0;
    bus.bus_ack = 0; bus.bus_rdata = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.bus_req, bus.bus_we, bus.bus_wstrb} !== 6'd0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0", {bus.bus_req, bus.bus_we, bus.bus_wstrb});
    end
    checks++;
    if (bus.bus_addr !== 32'd0 || bus.bus_wdata !== 32'd0 || mem_data_mem !== 32'd0) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h data=%h want 0", bus.bus_addr, bus.bus_wdata, mem_data_mem);
    end
    checks++;
    if ({stall, wb_bubble, misalign, bus_err} !== 4'd0) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {stall, wb_bubble, misalign, bus_err});
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_lw;
    run_access(1, 0, 3'd2, 32'h100, 0, 0, 32'hDEADBEEF);
    checks++;
    if (a_stalls !== 2) begin errors++; $display("FAIL lw_stalls: got %0d want 2", a_stalls); end
    checks++;
    if (a_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", a_data); end
    checks++;
    if (a_we !== 1'b0 || a_addr !== 32'h100 || a_wstrb !== 4'b0000) begin
      errors++; $display("FAIL lw_bus: we=%b addr=%h strb=%b want 0/100/0000", a_we, a_addr, a_wstrb);
    end
  endtask

  task automatic test_load_format;
    run_access(1, 0, 3'd0, 32'h103, 0, 0, 32'h80FF0000);
    checks++;
    if (a_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb: got %h want ffffff80", a_data); end
    run_access(1, 0, 3'd4, 32'h103, 0, 0, 32'h80FF0000);
    checks++;
    if (a_data !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h want 00000080", a_data); end
    run_access(1, 0, 3'd1, 32'h102, 0, 1, 32'h80FF0000);
    checks++;
    if (a_data !== 32'hFFFF80FF) begin errors++; $display("FAIL lh: got %h want ffff80ff", a_data); end
    checks++;
    if (a_stalls !== 3) begin errors++; $display("FAIL lh_stalls: got %0d want 3", a_stalls); end
    run_access(1, 0, 3'd5, 32'h102, 0, 0, 32'h80FF0000);
    checks++;
    if (a_data !== 32'h000080FF) begin errors++; $display("FAIL lhu: got %h want 000080ff", a_data); end
    run_access(1, 0, 3'd0, 32'h100, 0, 0, 32'h1234567F);
    checks++;
    if (a_data !== 32'h0000007F) begin errors++; $display("FAIL lb_pos: got %h want 0000007f", a_data); end
    run_access(1, 0, 3'd3, 32'h108, 0, 0, 32'h11223344);
    checks++;
    if (a_data !== 32'h11223344) begin errors++; $display("FAIL ld_undef: got %h want 11223344", a_data); end
  endtask

  task automatic test_store;
    run_access(0, 1, 3'd1, 32'h202, 32'h1234ABCD, 5, 32'hFFFFFFFF);
    checks++;
    if (a_we !== 1'b1 || a_addr !== 32'h200) begin
      errors++; $display("FAIL sh_we_addr: we=%b addr=%h want 1/00000200", a_we, a_addr);
    end
    checks++;
    if (a_wstrb !== 4'b1100 || a_wdata !== 32'hABCDABCD) begin
      errors++; $display("FAIL sh_payload: strb=%b wdata=%h want 1100/abcdabcd", a_wstrb, a_wdata);
    end
    checks++;
    if (a_stable !== 1'b1) begin errors++; $display("FAIL sh_stable: got %b want 1", a_stable); end
    checks++;
    if (a_stalls !== 7) begin errors++; $display("FAIL sh_stalls: got %0d want 7", a_stalls); end
    checks++;
    if (a_data !== 32'd0) begin errors++; $display("FAIL sh_data: got %h want 0", a_data); end
    run_access(0, 1, 3'd0, 32'h001, 32'h0000005A, 1, 0);
    checks++;
    if (a_wstrb !== 4'b0010 || a_wdata !== 32'h5A5A5A5A || a_addr !== 32'h0) begin
      errors++; $display("FAIL sb: strb=%b wdata=%h addr=%h want 0010/5a5a5a5a/0", a_wstrb, a_wdata, a_addr);
    end
    run_access(0, 1, 3'd2, 32'h300, 32'hCAFEF00D, 0, 0);
    checks++;
    if (a_wstrb !== 4'b1111 || a_wdata !== 32'hCAFEF00D || a_addr !== 32'h300) begin
      errors++; $display("FAIL sw: strb=%b wdata=%h addr=%h want 1111/cafef00d/300", a_wstrb, a_wdata, a_addr);
    end
  endtask

  task automatic test_misalign;
    bit req_seen;
    req_seen = 0;
    @(posedge clk); #1;
    mem_read_mem = 1; funct3_mem = 3'd2; addr_mem = 32'h101;
    @(negedge clk);
    checks++;
    if ({misalign, stall, wb_bubble, bus.bus_req} !== 4'b1010) begin
      errors++; $display("FAIL mis_lw: mis/stall/bub/req=%b want 1010", {misalign, stall, wb_bubble, bus.bus_req});
    end
    @(posedge clk); #1;
    mem_read_mem = 0;
    @(negedge clk);
    checks++;
    if (misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b want 0", misalign); end
    for (int i = 0; i < 3; i++) begin
      if (bus.bus_req) req_seen = 1;
      @(negedge clk);
    end
    checks++;
    if (req_seen) begin errors++; $display("FAIL mis_noreq: bus_req rose, want never"); end
    @(posedge clk); #1;
    mem_write_mem = 1; funct3_mem = 3'd1; addr_mem = 32'h203;
    @(negedge clk);
    checks++;
    if ({misalign, stall} !== 2'b10) begin
      errors++; $display("FAIL mis_sh: mis/stall=%b want 10", {misalign, stall});
    end
    @(posedge clk); #1 mem_write_mem = 0;
  endtask

  task automatic test_reset_busy;
    @(posedge clk); #1;
    mem_read_mem = 1; funct3_mem = 3'd2; addr_mem = 32'h400;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.bus_req !== 1'b1) begin errors++; $display("FAIL rb_busy: req=%b want 1", bus.bus_req); end
    reset = 1'b1; #1;
    checks++;
    if (bus.bus_req !== 1'b0 || int'(dut.r_state) != 0) begin
      errors++; $display("FAIL rb_drop: req=%b state=%0d want 0/0", bus.bus_req, int'(dut.r_state));
    end
    mem_read_mem = 0; #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL rb_stall: got %b want 0", stall); end
    @(posedge clk); #1 reset = 1'b0;
    run_access(1, 0, 3'd2, 32'h404, 0, 2, 32'h0BADF00D);
    checks++;
    if (a_data !== 32'h0BADF00D || a_stalls !== 4) begin
      errors++; $display("FAIL rb_after: data=%h stalls=%0d want 0badf00d/4", a_data, a_stalls);
    end
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'h55555555;
    @(negedge clk);
    @(posedge clk); #1;
    bus.bus_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.bus_req !== 1'b0 || stall !== 1'b0 || int'(dut.r_state) != 0) begin
      errors++; $display("FAIL stray_ack: req=%b stall=%b state=%0d want 0/0/0", bus.bus_req, stall, int'(dut.r_state));
    end
    run_access(1, 0, 3'd2, 32'h500, 0, 0, 32'hA5A5A5A5);
    run_access(1, 0, 3'd4, 32'h501, 0, 0, 32'h0000C300);
    checks++;
    if (a_data !== 32'h000000C3 || a_stalls !== 2) begin
      errors++; $display("FAIL b2b: data=%h stalls=%0d want 000000c3/2", a_data, a_stalls);
    end
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout;
    run_access(1, 0, 3'd2, 32'h600, 0, -1, 0);
    checks++;
    if (a_stalls !== 5) begin errors++; $display("FAIL to_stalls: got %0d want 5", a_stalls); end
    checks++;
    if (a_err !== 1'b1 || a_data !== 32'd0) begin
      errors++; $display("FAIL to_done: err=%b data=%h want 1/0", a_err, a_data);
    end
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b0) begin errors++; $display("FAIL to_pulse: got %b want 0", bus_err); end
  endtask
`endif

  initial begin
    test_reset;
    test_lw;
    test_load_format;
    test_store;
    test_misalign;
    test_reset_busy;
    test_back_to_back;
`ifdef DMEM_TIMEOUT_EN
    test_timeout;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
